// File: rtl/uart_ctrl.sv
// CPU-side UART controller: DATA/STATUS MMIO slave, RX/TX byte FIFOs and transmit sequencer.
// Optional interrupt output and STATUS[7] enable are built with UART_IRQ_EN.
module uart_ctrl #(
   parameter int RX_DEPTH = 8,
   parameter int TX_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bus_ce,
   input  logic       bus_we,
   input  logic       bus_addr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic       bus_ack,
   output logic       rx_ce,
   input  logic       rx_fin,
   input  logic [7:0] rx_data,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy
`ifdef UART_IRQ_EN
   ,
   output logic       irq
`endif
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_CW = RX_AW + 1;
   localparam int TX_CW = TX_AW + 1;
   localparam logic [RX_AW:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, START, WAITB} tx_state_t;

   logic [7:0]       rx_mem [RX_DEPTH];
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [RX_AW-1:0] rx_wp, rx_rp;
   logic [TX_AW-1:0] tx_wp, tx_rp;
   logic [RX_AW:0]   rx_cnt;
   logic [TX_AW:0]   tx_cnt;
   logic             rx_fin_q, rx_ovr, tx_ovr, irq_en;
   tx_state_t        state, state_nx;

   logic rd_data, rd_stat, wr_data;
   logic rx_full, rx_valid, rx_edge, rx_push, rx_pop, rx_ovr_set;
   logic tx_full, tx_empty, tx_push, tx_pop, tx_ovr_set, tx_idle;
   logic [7:0] status;

   assign rd_data = bus_ce & ~bus_we & ~bus_addr;
   assign rd_stat = bus_ce & ~bus_we &  bus_addr;
   assign wr_data = bus_ce &  bus_we & ~bus_addr;

   // A pop in the same cycle frees a slot, so a push at full still succeeds.
   assign rx_full    = (rx_cnt == RX_FULL_CNT);
   assign rx_valid   = (rx_cnt != '0);
   assign rx_edge    = rx_fin & ~rx_fin_q;
   assign rx_pop     = rd_data & rx_valid;
   assign rx_push    = rx_edge & (~rx_full | rx_pop);
   assign rx_ovr_set = rx_edge & rx_full & ~rx_pop;

   assign tx_full    = (tx_cnt == TX_FULL_CNT);
   assign tx_empty   = (tx_cnt == '0);
   assign tx_push    = wr_data & (~tx_full | tx_pop);
   assign tx_ovr_set = wr_data & tx_full & ~tx_pop;
   assign tx_idle    = tx_empty & (state == IDLE) & ~tx_busy;

   assign status = {irq_en, 2'b00, tx_idle, tx_ovr, rx_ovr, rx_valid, ~tx_full};

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= rx_data;
      if (tx_push) tx_mem[tx_wp] <= bus_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wp     <= '0;
         rx_rp     <= '0;
         rx_cnt    <= '0;
         rx_fin_q  <= 1'b0;
         rx_ovr    <= 1'b0;
         rx_ce     <= 1'b0;
         bus_ack   <= 1'b0;
         bus_rdata <= '0;
      end else begin
         rx_fin_q <= rx_fin;
         rx_ce    <= ~rx_full;
         bus_ack  <= bus_ce;
         if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
         if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + RX_CW'(1);
         else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - RX_CW'(1);
         if (rx_ovr_set)   rx_ovr <= 1'b1;
         else if (rd_stat) rx_ovr <= 1'b0;
         if (rd_data)      bus_rdata <= rx_valid ? rx_mem[rx_rp] : 8'h00;
         else if (rd_stat) bus_rdata <= status;
      end
   end

   always_comb begin
      state_nx = state;
      tx_pop   = 1'b0;
      case (state)
         IDLE:  if (!tx_empty && !tx_busy) begin
                   state_nx = LOAD;
                   tx_pop   = 1'b1;
                end
         LOAD:  state_nx = START;
         START: if (tx_busy) state_nx = WAITB;
         WAITB: if (!tx_busy) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // tx_start is a flop that is high exactly while the FSM sits in LOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_cnt   <= '0;
         tx_ovr   <= 1'b0;
      end else begin
         state    <= state_nx;
         tx_start <= (state_nx == LOAD);
         if (tx_pop)  tx_data <= tx_mem[tx_rp];
         if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
         if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + TX_CW'(1);
         else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - TX_CW'(1);
         if (tx_ovr_set)   tx_ovr <= 1'b1;
         else if (rd_stat) tx_ovr <= 1'b0;
      end
   end

`ifdef UART_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (bus_ce && bus_we && bus_addr) irq_en <= bus_wdata[7];
         irq <= irq_en & (rx_valid | rx_ovr);
      end
   end
`else
   assign irq_en = 1'b0;
`endif

endmodule
